// File: rtl/arith_pkg.sv
// Shared constants and FSM state type for the fixed-point arithmetic blocks.
// Q8.8 operands, Q16.16 squares, and the 8-bit saturated integer view of them.
package arith_pkg;

    localparam int          WIDTH      = 16;
    localparam int          FRAC       = 8;
    localparam int          INT_MAX    = 255;
    localparam logic [31:0] ROUND_HALF = 32'h0000_8000;
    localparam int          CNT_W      = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/square_round_sat.sv
// Rounds a Q16.16 value half-up to its integer part and saturates it to 8 bits.
// Purely combinational so it can be shared by the square-root checker.
module square_round_sat
    import arith_pkg::*;
#(
    parameter int FRAC_BITS = FRAC
) (
    input  logic [31:0] sq,
    output logic [7:0]  int_out,
    output logic        ovf
);

    logic [32:0] rounded;
    logic [32:0] r;

    // One extra bit so adding the half never wraps for sq near 0xFFFFFFFF.
    assign rounded = {1'b0, sq} + {1'b0, ROUND_HALF};
    assign r       = rounded >> (2 * FRAC_BITS);
    assign ovf     = (r > 33'(INT_MAX));
    assign int_out = ovf ? 8'(INT_MAX) : r[7:0];

endmodule

// File: rtl/square_seq.sv
// Sequential Q8.8 squarer: 16-step shift-add producing an exact Q16.16 square
// plus a rounded, saturated 8-bit integer, behind valid/ready handshakes.
module square_seq
    import arith_pkg::*;
#(
    parameter int W = WIDTH,
    parameter int F = FRAC
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] sq,
    output logic [7:0]     int_out,
    output logic           ovf
);

    state_t           state;
    state_t           state_next;
    logic [2*W-1:0]   acc;
    logic [2*W-1:0]   acc_next;
    logic [2*W-1:0]   mcand;
    logic [W-1:0]     mplr;
    logic [CNT_W-1:0] cnt;
    logic             last_step;
    logic [7:0]       rs_int;
    logic             rs_ovf;

    // The rounding sees the accumulator including this cycle's partial product.
    assign acc_next  = acc + (mplr[0] ? mcand : '0);
    assign last_step = (cnt == CNT_W'(W - 1));

    square_round_sat #(
        .FRAC_BITS (F)
    ) u_round_sat (
        .sq      (acc_next),
        .int_out (rs_int),
        .ovf     (rs_ovf)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        // NOTE: default first so no path leaves state_next unassigned (no latch).
        state_next = state;
        unique case (state)
            IDLE:    if (in_valid)  state_next = CALC;
            CALC:    if (last_step) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc     <= '0;
            mcand   <= '0;
            mplr    <= '0;
            cnt     <= '0;
            sq      <= '0;
            int_out <= '0;
            ovf     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        acc   <= '0;
                        mcand <= {{W{1'b0}}, in};
                        mplr  <= in;
                        cnt   <= '0;
                    end
                end
                CALC: begin
                    acc   <= acc_next;
                    mcand <= mcand << 1;
                    mplr  <= mplr >> 1;
                    cnt   <= cnt + 1'b1;
                    if (last_step) begin
                        sq      <= acc_next;
                        int_out <= rs_int;
                        ovf     <= rs_ovf;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_square_seq.sv
// Scoreboard bench for square_seq: directed operands with hand-computed squares,
// latency, backpressure and mid-calculation reset.
module tb_square_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sq;
    logic [7:0]  int_out;
    logic        ovf;

    square_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in        (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sq        (sq),
        .int_out   (int_out),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] sq;
        logic [7:0]  iv;
        logic        ovf;
        int          acc_cyc;
    } exp_t;

    typedef struct {
        logic [15:0] op;
        logic [31:0] sq;
        logic [7:0]  iv;
        logic        ovf;
    } vec_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    vec_t vecs[9] = '{
        '{16'h0280, 32'h0006_4000, 8'd6,   1'b0},
        '{16'h0C80, 32'h009C_4000, 8'd156, 1'b0},
        '{16'h00B5, 32'h0000_7FF9, 8'd0,   1'b0},
        '{16'h016A, 32'h0001_FFE4, 8'd2,   1'b0},
        '{16'h0000, 32'h0000_0000, 8'd0,   1'b0},
        '{16'h0FF8, 32'h00FF_0040, 8'd255, 1'b0},
        '{16'h0FFF, 32'h00FF_E001, 8'd255, 1'b1},
        '{16'h1000, 32'h0100_0000, 8'd255, 1'b1},
        '{16'hFFFF, 32'hFFFE_0001, 8'd255, 1'b1}
    };

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: wait bound expired at cycle %0d", name, cyc);
    endtask

    task automatic send(input logic [15:0] op, input logic [31:0] esq,
                        input logic [7:0] eint, input logic eovf, input bit track);
        int budget;
        budget = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 100) begin
            timeout("send_in_ready");
            return;
        end
        in_valid = 1'b1;
        in_op    = op;
        @(posedge clk);
        #1;
        if (track) sb.push_back('{esq, eint, eovf, cyc});
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int budget;
        budget = 0;
        while ((sb.size() != 0 || in_ready !== 1'b1) && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 100) timeout(name);
    endtask

    // Monitor: one comparison set per rising out_valid.
    initial begin
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1 && !prev) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_output: got sq=0x%0h expected no result (cycle %0d)", sq, cyc);
                end else begin
                    e = sb.pop_front();
                    check("sq", sq, e.sq);
                    check("int_out", 32'(int_out), 32'(e.iv));
                    check("ovf", 32'(ovf), 32'(e.ovf));
                    check("latency", 32'(cyc - e.acc_cyc), 32'd16);
                end
            end
            prev = (out_valid === 1'b1);
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int budget;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_op     = 16'h0000;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_sq", sq, 32'd0);
        check("reset_int_out", 32'(int_out), 32'd0);
        check("reset_ovf", 32'(ovf), 32'd0);
        rst = 1'b0;

        foreach (vecs[i]) send(vecs[i].op, vecs[i].sq, vecs[i].iv, vecs[i].ovf, 1'b1);
        drain("drain_directed");

        // Backpressure: result must hold and no operand may be captured.
        out_ready = 1'b0;
        send(16'h0C80, 32'h009C_4000, 8'd156, 1'b0, 1'b1);
        budget = 0;
        while (out_valid !== 1'b1 && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 50) timeout("bp_out_valid");
        for (int i = 0; i < 5; i++) begin
            in_op    = 16'h1111 * 16'(i + 1);
            in_valid = ~in_valid;
            check("bp_sq_hold", sq, 32'h009C_4000);
            check("bp_int_hold", 32'(int_out), 32'd156);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_out_valid", 32'(out_valid), 32'd0);
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        repeat (20) @(negedge clk);

        // Reset in the middle of a calculation discards it.
        send(16'h0280, 32'h0006_4000, 8'd6, 1'b0, 1'b0);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_sq", sq, 32'd0);
        check("midrst_int_out", 32'(int_out), 32'd0);
        check("midrst_ovf", 32'(ovf), 32'd0);
        repeat (25) @(negedge clk);
        send(16'h0180, 32'h0002_4000, 8'd2, 1'b0, 1'b1);
        drain("drain_after_reset");
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
